// File: rtl/word_line_sequencer.sv
// Clocked SRAM word-line sequencer: handshake-driven precharge, one-hot
// word-line pulse and sense strobe, ending in a one-cycle done pulse.
// Optional build macro SEQ_BACK_TO_BACK_EN lets a new request be accepted
// in the DONE cycle, removing the idle gap between accesses.
module word_line_sequencer #(
  parameter int ADDR_W     = 3,
  parameter int NUM_WORDS  = 8,
  parameter int PRE_CYCLES = 1,
  parameter int WL_CYCLES  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic                 req_write,
  output logic                 precharge,
  output logic [NUM_WORDS-1:0] word_select,
  output logic                 write_enable,
  output logic                 sense_enable,
  output logic                 done,
  output logic                 addr_err
);

  localparam int MAX_CYC = (PRE_CYCLES > WL_CYCLES) ? PRE_CYCLES : WL_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] PRE_LOAD = CNT_W'(PRE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WL_LOAD  = CNT_W'(WL_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ACT   = 3'd2,
    S_SENSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_lat;
  logic              write_lat;
  logic              err_lat;
  logic              rst_hold;
  logic              accept;
  logic              addr_oob;
  logic [31:0]       addr_ext;
  logic [31:0]       addr_lat_ext;

  // Range check done at full integer width so NUM_WORDS == 2**ADDR_W needs no special case.
  assign addr_ext     = 32'(req_addr);
  assign addr_lat_ext = 32'(addr_lat);
  assign addr_oob     = (addr_ext >= 32'(NUM_WORDS));
  assign accept       = req_valid & req_ready;

  // State register; rst_hold keeps req_ready low for the cycle following a reset edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      rst_hold <= 1'b1;
    end else begin
      state    <= state_nxt;
      rst_hold <= 1'b0;
    end
  end

  // Phase counter: reloads on entry to a timed phase, counts down to zero, never wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state_nxt == S_PRE && state != S_PRE) begin
      cnt <= PRE_LOAD;
    end else if (state_nxt == S_ACT && state != S_ACT) begin
      cnt <= WL_LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Request capture: address/direction are data and carry no reset; the error flag is control.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_lat  <= req_addr;
      write_lat <= req_write;
    end
  end

  // Out-of-range flag for the access in flight, qualifies addr_err in DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_lat <= 1'b0;
    end else if (accept) begin
      err_lat <= addr_oob;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = addr_oob ? S_DONE : S_PRE;
      S_PRE:   if (cnt == '0) state_nxt = S_ACT;
      S_ACT:   if (cnt == '0) state_nxt = write_lat ? S_DONE : S_SENSE;
      S_SENSE: state_nxt = S_DONE;
`ifdef SEQ_BACK_TO_BACK_EN
      S_DONE:  state_nxt = accept ? (addr_oob ? S_DONE : S_PRE) : S_IDLE;
`else
      S_DONE:  state_nxt = S_IDLE;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode, purely from the current state and latched request.
  always_comb begin
    req_ready    = 1'b0;
    precharge    = 1'b0;
    word_select  = '0;
    write_enable = 1'b0;
    sense_enable = 1'b0;
    done         = 1'b0;
    addr_err     = 1'b0;
`ifdef SEQ_BACK_TO_BACK_EN
    req_ready    = !rst_hold && (state == S_IDLE || state == S_DONE);
`else
    req_ready    = !rst_hold && (state == S_IDLE);
`endif
    precharge    = (state == S_PRE);
    write_enable = (state == S_ACT) && write_lat;
    sense_enable = (state == S_SENSE);
    done         = (state == S_DONE);
    addr_err     = (state == S_DONE) && err_lat;
    for (int unsigned i = 0; i < NUM_WORDS; i++) begin
      word_select[i] = (state == S_ACT) && (addr_lat_ext == i);
    end
  end

endmodule
